led_sequencer: RTL and testbench

LED_SEQUENCER -- requirements
Module: led_sequencer

---
 rtl/led_seq_pkg.sv | 42 ++++
 rtl/btn_debounce.sv | 51 +++++
 rtl/led_sequencer.sv | 142 ++++++++++++++
 tb/tb_led_sequencer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED sequencer: mode encodings, PWM width
// and the logical RGB bundle.
package led_seq_pkg;

  localparam int PWM_W = 8;
  localparam logic [PWM_W-1:0] PWM_MAX = '1;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_BLINK   = 2'd1,
    MODE_BREATHE = 2'd2,
    MODE_CYCLE   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    COLOR_R = 2'd0,
    COLOR_G = 2'd1,
    COLOR_B = 2'd2
  } color_e;

  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } rgb_t;

  localparam rgb_t RGB_OFF = '{r: 1'b0, g: 1'b0, b: 1'b0};

  function automatic mode_e next_mode(input mode_e m);
    unique case (m)
      MODE_OFF:     return MODE_BLINK;
      MODE_BLINK:   return MODE_BREATHE;
      MODE_BREATHE: return MODE_CYCLE;
      default:      return MODE_OFF;
    endcase
  endfunction

  function automatic color_e next_color(input color_e c);
    return (c == COLOR_B) ? COLOR_R : color_e'(c + 2'd1);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button front end: 2-flop synchronizer, tick-based debouncer and a one-cycle
// press strobe on the debounced released->pressed transition (btn is active-low).
module btn_debounce #(
  parameter int DEBOUNCE_TICKS = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic i_tick,
  input  logic i_btn,
  output logic o_press
);

  localparam int CNT_W = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_state;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;

  // NOTE: every flop here is state, so all updates use <= to avoid ordering races.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: synchronizer and debounced state reset to 1 (released) so no press is faked.
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_state <= 1'b1;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (i_tick) begin
        if (r_sync2 == r_state) begin
          r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
          r_state <= r_sync2;
          r_cnt   <= '0;
          r_press <= ~r_sync2;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/led_sequencer.sv
// RGB LED sequencer: tick prescaler, button-driven mode FSM (OFF/BLINK/BREATHE/
// CYCLE) and an 8-bit PWM, with registered polarity-corrected LED pins.
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int TICK_DIV       = 48000,
  parameter int DEBOUNCE_TICKS = 20,
  parameter int BLINK_TICKS    = 500,
  parameter int CYCLE_TICKS    = 1000,
  parameter bit LED_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn,
  output logic       r,
  output logic       g,
  output logic       b,
  output logic [1:0] mode,
  output logic       tick
);

  localparam int PRESC_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int PHASE_MAX = (BLINK_TICKS > CYCLE_TICKS) ? BLINK_TICKS : CYCLE_TICKS;
  localparam int PHASE_W   = (PHASE_MAX > 1) ? $clog2(PHASE_MAX) : 1;

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [PHASE_W-1:0] BLINK_LAST = PHASE_W'(BLINK_TICKS - 1);
  localparam logic [PHASE_W-1:0] CYCLE_LAST = PHASE_W'(CYCLE_TICKS - 1);
  localparam rgb_t               PIN_OFF    = {3{LED_ACTIVE_LOW}};

  logic [PRESC_W-1:0] r_presc;
  logic               w_tick;
  logic               w_press;

  mode_e              r_mode;
  logic [PHASE_W-1:0] r_phase;
  logic               r_blink_off;
  logic [PWM_W-1:0]   r_level;
  logic               r_level_up;
  color_e             r_color;
  logic [PWM_W-1:0]   r_pwm;

  rgb_t               w_led;
  rgb_t               r_pin;

  assign w_tick = (r_presc == PRESC_LAST);

  always_ff @(posedge clk) begin
    if (reset || w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  btn_debounce #(
    .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
  ) u_btn_debounce (
    .clk     (clk),
    .reset   (reset),
    .i_tick  (w_tick),
    .i_btn   (btn),
    .o_press (w_press)
  );

  // A press always wins over a coincident tick: the new mode starts from a clean phase.
  always_ff @(posedge clk) begin
    if (reset || w_press) begin
      r_mode      <= reset ? MODE_OFF : next_mode(r_mode);
      r_phase     <= '0;
      r_blink_off <= 1'b0;
      r_level     <= '0;
      r_level_up  <= 1'b1;
      r_color     <= COLOR_R;
    end else if (w_tick) begin
      unique case (r_mode)
        MODE_BLINK: begin
          if (r_phase == BLINK_LAST) begin
            r_phase     <= '0;
            r_blink_off <= ~r_blink_off;
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end
        MODE_BREATHE: begin
          if (r_level_up) begin
            r_level <= r_level + 1'b1;
            if (r_level == PWM_MAX - 1'b1) r_level_up <= 1'b0;
          end else begin
            r_level <= r_level - 1'b1;
            if (r_level == PWM_W'(1)) r_level_up <= 1'b1;
          end
        end
        MODE_CYCLE: begin
          if (r_phase == CYCLE_LAST) begin
            r_phase <= '0;
            r_color <= next_color(r_color);
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pwm <= '0;
    end else begin
      r_pwm <= r_pwm + 1'b1;
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns w_led and no latch is inferred.
    w_led = RGB_OFF;
    unique case (r_mode)
      MODE_OFF:     w_led = RGB_OFF;
      MODE_BLINK:   w_led = '{r: ~r_blink_off, g: ~r_blink_off, b: ~r_blink_off};
      MODE_BREATHE: w_led.g = (r_pwm < r_level);
      MODE_CYCLE:   w_led = '{r: (r_color == COLOR_R), g: (r_color == COLOR_G),
                              b: (r_color == COLOR_B)};
      default:      w_led = RGB_OFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pin <= PIN_OFF;
    end else begin
      r_pin <= w_led ^ PIN_OFF;
    end
  end

  assign r    = r_pin.r;
  assign g    = r_pin.g;
  assign b    = r_pin.b;
  assign mode = r_mode;
  assign tick = w_tick;

endmodule

// File: tb/tb_led_sequencer.sv
// Scoreboard bench for led_sequencer: a cycle-level reference model derives the
// expected pins/mode/tick from tick counts since mode entry; a monitor compares.
module tb_led_sequencer;
  import led_seq_pkg::*;

  localparam int TD = 4;
  localparam int DB = 3;
  localparam int BT = 2;
  localparam int CT = 2;
  localparam bit AL = 1'b1;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       btn   = 1'b1;
  logic       r, g, b, tick;
  logic [1:0] mode;

  led_sequencer #(
    .TICK_DIV       (TD),
    .DEBOUNCE_TICKS (DB),
    .BLINK_TICKS    (BT),
    .CYCLE_TICKS    (CT),
    .LED_ACTIVE_LOW (AL)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .btn   (btn),
    .r     (r),
    .g     (g),
    .b     (b),
    .mode  (mode),
    .tick  (tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] mode;
    logic       r;
    logic       g;
    logic       b;
    logic       tick;
  } obs_t;

  obs_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: mode outputs are closed-form in n = ticks since the mode was entered.
  initial begin : ref_model
    int   c, n, m_mode, lev, idx;
    bit   s1, s2, deb, press_pend, lr, lg, lb, tick_before, all_diff;
    bit   samp[$];
    obs_t e;
    c = 0; n = 0; m_mode = 0; s1 = 1'b1; s2 = 1'b1; deb = 1'b1; press_pend = 1'b0;
    lr = 1'b0; lg = 1'b0; lb = 1'b0;
    forever begin
      @(posedge clk);
      if (reset) begin
        c = 0; n = 0; m_mode = 0; s1 = 1'b1; s2 = 1'b1; deb = 1'b1; press_pend = 1'b0;
        samp.delete();
        lr = 1'b0; lg = 1'b0; lb = 1'b0;
        e = '{mode: 2'd0, r: AL, g: AL, b: AL, tick: 1'b0};
      end else begin
        tick_before = (c % TD) == TD - 1;
        e.r = lr ^ AL;
        e.g = lg ^ AL;
        e.b = lb ^ AL;
        if (press_pend) begin
          m_mode = (m_mode + 1) % 4;
          n = 0;
        end else if (tick_before) begin
          n++;
        end
        press_pend = 1'b0;
        // Debounced state flips once the last DB tick samples all disagree with it.
        if (tick_before) begin
          samp.push_back(s2);
          if (samp.size() > DB) void'(samp.pop_front());
          if (samp.size() == DB) begin
            all_diff = 1'b1;
            foreach (samp[i]) if (samp[i] == deb) all_diff = 1'b0;
            if (all_diff) begin
              press_pend = deb;
              deb = ~deb;
            end
          end
        end
        s2 = s1;
        s1 = btn;
        c++;
        case (m_mode)
          1: begin
            lr = ((n / BT) % 2) == 0; lg = lr; lb = lr;
          end
          2: begin
            lev = n % 510;
            if (lev > 255) lev = 510 - lev;
            lr = 1'b0; lb = 1'b0;
            lg = (c % 256) < lev;
          end
          3: begin
            idx = (n / CT) % 3;
            lr = (idx == 0); lg = (idx == 1); lb = (idx == 2);
          end
          default: begin
            lr = 1'b0; lg = 1'b0; lb = 1'b0;
          end
        endcase
        e.mode = 2'(m_mode);
        e.tick = (c % TD) == TD - 1;
      end
      sb.push_back(e);
    end
  end

  initial begin : monitor
    obs_t e;
    forever begin
      @(negedge clk);
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_empty at %0t: got no expected entry, required one per cycle", $time);
      end else begin
        e = sb.pop_front();
        check("mode", {2'b00, mode}, {2'b00, e.mode});
        check("leds", {1'b0, r, g, b}, {1'b0, e.r, e.g, e.b});
        check("tick", {3'b000, tick}, {3'b000, e.tick});
      end
    end
  end

  task automatic idle(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  task automatic press(input int hold_ticks);
    repeat ($urandom_range(0, 3)) begin
      btn = 1'b0; idle(1);
      btn = 1'b1; idle(1);
    end
    btn = 1'b0;
    idle(hold_ticks * TD + int'($urandom_range(0, TD - 1)));
    btn = 1'b1;
    idle((DB + 2) * TD + int'($urandom_range(0, TD - 1)));
  endtask

  initial begin : stimulus
    reset = 1'b1;
    btn   = 1'b1;
    idle(3);
    reset = 1'b0;
    idle(40);
    // Low for only two ticks must not count as a press.
    btn = 1'b0; idle(2 * TD - 2);
    btn = 1'b1; idle(6 * TD);
    press(DB + 2);
    idle(12 * BT * TD);
    press(DB + 2);
    idle(560 * TD);
    press(DB + 2);
    idle(10 * CT * TD);
    press(DB + 2);
    idle(20);
    press(DB + 2);
    press(DB + 2);
    idle(100 * TD + int'($urandom_range(0, 7)));
    reset = 1'b1; idle(1);
    reset = 1'b0; idle(30);
    // Button held through reset yields exactly one press afterwards.
    btn = 1'b0; reset = 1'b1; idle(2);
    reset = 1'b0; idle((DB + 4) * TD);
    btn = 1'b1; idle((DB + 3) * TD);
    for (int k = 0; k < 60; k++) begin
      btn = 1'($urandom_range(0, 1));
      idle(int'($urandom_range(1, 6 * TD)));
    end
    btn = 1'b1;
    idle(10 * TD);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
